// File: rtl/data_mem_unit_if.sv
// Pipeline-to-data-memory bus for the MEM stage: request, size code, store data,
// and the load result with its stall/done/fault handshake.
interface data_mem_unit_if #(
    parameter int NB_WIDTH = 32
);
    logic [NB_WIDTH-1:0] i_mem_addr;
    logic [NB_WIDTH-1:0] i_mem_data;
    logic                i_mem_read_CU;
    logic                i_mem_write_CU;
    logic [2:0]          i_BHW_CU;
    logic [NB_WIDTH-1:0] o_read_data;
    logic                o_stall;
    logic                o_done;
    logic                o_fault;

    modport master (
        output i_mem_addr, i_mem_data, i_mem_read_CU, i_mem_write_CU, i_BHW_CU,
        input  o_read_data, o_stall, o_done, o_fault
    );

    modport slave (
        input  i_mem_addr, i_mem_data, i_mem_read_CU, i_mem_write_CU, i_BHW_CU,
        output o_read_data, o_stall, o_done, o_fault
    );
endinterface

// File: rtl/data_mem_unit.sv
// Byte-addressed little-endian data RAM with sized/sign-extended loads,
// programmable wait states via a stall handshake, and alignment fault detection.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | accepting requests; zero-wait accesses complete here
//   ST_WAIT | counting down wait states; access fires when counter hits 0
module data_mem_unit #(
    parameter int NB_WIDTH    = 32,
    parameter int NB_ADDR     = 9,
    parameter int NB_DATA     = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    data_mem_unit_if.slave  mem_if
);
    localparam int NB_LANES = NB_WIDTH / NB_DATA;
    localparam int NB_LSB   = $clog2(NB_LANES);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NB_WIDTH-1:0] rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;

    logic [NB_DATA-1:0]  mem_q [2**NB_ADDR];

    logic [NB_ADDR-1:0]  addr_idx;
    logic [NB_LANES-1:0] lane_en;
    logic                illegal;
    logic                misaligned;
    logic                req;
    logic                bad;
    logic                access;
    logic                stall;
    logic [NB_WIDTH-1:0] raw_word;
    logic [NB_WIDTH-1:0] load_val;
    logic                sgn;
    logic                addr_unused;

    assign addr_idx    = mem_if.i_mem_addr[NB_ADDR-1:0];
    assign addr_unused = ^mem_if.i_mem_addr[NB_WIDTH-1:NB_ADDR];
    assign req         = mem_if.i_mem_read_CU | mem_if.i_mem_write_CU;
    assign bad         = illegal | misaligned;
    assign sgn         = ~mem_if.i_BHW_CU[2];

    always_comb begin
        lane_en    = '0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (mem_if.i_BHW_CU)
            3'b000, 3'b100: lane_en = NB_LANES'(1);
            3'b001, 3'b101: begin
                lane_en    = NB_LANES'(3);
                misaligned = mem_if.i_mem_addr[0];
            end
            3'b011: begin
                lane_en    = '1;
                misaligned = |mem_if.i_mem_addr[NB_LSB-1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Lanes wrap modulo the RAM size, matching the ignored upper address bits.
    always_comb begin
        raw_word = '0;
        for (int i = 0; i < NB_LANES; i++) begin
            raw_word[i*NB_DATA +: NB_DATA] = mem_q[addr_idx + NB_ADDR'(i)];
        end
    end

    always_comb begin
        load_val = raw_word;
        case (mem_if.i_BHW_CU)
            3'b000, 3'b100:
                load_val = {{(NB_WIDTH-NB_DATA){raw_word[NB_DATA-1] & sgn}},
                            raw_word[NB_DATA-1:0]};
            3'b001, 3'b101:
                load_val = {{(NB_WIDTH-2*NB_DATA){raw_word[2*NB_DATA-1] & sgn}},
                            raw_word[2*NB_DATA-1:0]};
            default: load_val = raw_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        access  = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bad) begin
                        fault_d = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        access = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = WS - 4'd1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        done_d  = access;
        rdata_d = (access && !mem_if.i_mem_write_CU) ? load_val : rdata_q;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // RAM has no reset; writes are gated so an in-reset edge never stores.
    always_ff @(posedge i_clk) begin
        if (access && mem_if.i_mem_write_CU && i_reset) begin
            for (int i = 0; i < NB_LANES; i++) begin
                if (lane_en[i]) begin
                    mem_q[addr_idx + NB_ADDR'(i)] <= mem_if.i_mem_data[i*NB_DATA +: NB_DATA];
                end
            end
        end
    end

    assign mem_if.o_stall     = stall & i_reset;
    assign mem_if.o_done      = done_q;
    assign mem_if.o_fault     = fault_q;
    assign mem_if.o_read_data = rdata_q;
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised data-memory unit for the MIPS MEM stage. It holds a byte-addressed, little-endian data RAM and serves byte, halfword and word loads and stores with sign or zero extension. A configurable number of wait states is enforced through a stall handshake to the pipeline, and misaligned or illegal accesses are flagged without touching memory.

## Interface
Parameters:
- NB_WIDTH, 32, datapath width in bits (multiple of 4·NB_DATA/4; 32 in the core)
- NB_ADDR, 9, byte-address bits; RAM holds 2^NB_ADDR bytes
- NB_DATA, 8, bits per byte lane
- WAIT_STATES, 0, extra cycles per access, 0..15

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_mem_addr  in  NB_WIDTH  byte address; bits above NB_ADDR ignored (wraps modulo 2^NB_ADDR)
- i_mem_data  in  NB_WIDTH  store data, right-aligned
- i_mem_read_CU  in  1  load request
- i_mem_write_CU  in  1  store request
- i_BHW_CU  in  3  size/sign: 000 byte signed, 001 half signed, 011 word, 100 byte unsigned, 101 half unsigned; others illegal
- o_read_data  out  NB_WIDTH  registered, extended load result
- o_stall  out  1  combinational; pipeline must freeze and hold all inputs while high
- o_done  out  1  one-cycle pulse: access completed
- o_fault  out  1  one-cycle pulse: misaligned or illegal access rejected

## Operation
- Request = i_mem_read_CU | i_mem_write_CU. Both high: treated as store only.
- Byte at address A occupies bits [7:0] of a word; A+1 → [15:8], etc.
- Store byte: write i_mem_data[7:0] to A. Half: [15:0] to A, A+1. Word: all four bytes to A..A+3. Other bytes unchanged.
- Load: byte/half taken from A upward, sign-extended (000, 001) or zero-extended (100, 101); word returned unmodified. Stores ignore the sign bit of i_BHW_CU.
- Fault: half with A[0]=1, word with A[1:0]≠0, or illegal i_BHW_CU code. No memory write, o_read_data unchanged, no stall, no o_done.
- FSM: IDLE, WAIT.
  - IDLE, valid request, WAIT_STATES=0: access at this edge, stay IDLE.
  - IDLE, valid request, WAIT_STATES>0: load counter = WAIT_STATES-1, go WAIT.
  - WAIT, counter>0: decrement.
  - WAIT, counter=0: access at this edge, go IDLE.
- Inputs are not re-sampled in WAIT. The access uses the inputs present on the access edge; the pipeline guarantees they are stable.
- RAM contents are not affected by reset and are zero at configuration.

## Timing
- Reset (asynchronous, i_reset=0): state IDLE, counter 0, o_read_data 0, o_done 0, o_fault 0, o_stall 0.
- Reset asserted mid-access: pending store is abandoned, nothing written, o_done not produced.
- Request first presented in the cycle ending at edge k:
  - o_stall is high for exactly WAIT_STATES cycles, from that cycle onward.
  - The access occurs at edge k+WAIT_STATES.
  - o_done is high for the one cycle after that edge.
  - Load: o_read_data is valid from that cycle and holds until the next completed load.
- WAIT_STATES=0: o_stall never asserts; back-to-back accesses every cycle.
- A new request in the cycle after completion starts a fresh wait count; no request is skipped or merged.
- Fault: o_fault is high for the one cycle after edge k; o_stall stays 0 throughout.
- Request deasserted in IDLE: nothing happens, outputs hold (o_done/o_fault 0).

## Test plan
- WAIT_STATES=0. SW 0xDEADBEEF @12, then LB @12, LBU @13, LH @14, LHU @14, LW @12 -> o_read_data = 0xFFFFFFEF, 0x000000BE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF, each one cycle after its request edge; o_stall never high.
- Partial store merge. SW 0x11223344 @16, SB 0x000000AA @17, SH 0x0000BBCC @18, LW @16 -> 0xBBCCAA44.
- WAIT_STATES=3, LW @12 after the SW above. o_stall high for exactly 3 cycles, o_done pulses once in the 4th cycle after presentation, o_read_data = 0xDEADBEEF. A back-to-back second load stalls another 3 cycles.
- Faults. LH @9, SW @14, and i_BHW_CU=010 @0 -> o_fault pulse each, no stall, no o_done; a following LW @12 still returns 0xDEADBEEF.
- Address wrap, NB_ADDR=9. SB 0x5A @0x204, LBU @0x004 -> 0x0000005A.
- Reset mid-access, WAIT_STATES=3. SW 0xCAFEF00D @20, then drop i_reset after 1 stall cycle -> all outputs 0 immediately; after release, LW @20 returns the prior contents (0x00000000).
